// File: rtl/cache_line_fill_buffer_pkg.sv
// Shared definitions for the cache line fill buffer: FSM state encoding and
// helpers that derive line geometry from the cache parameters.
package cache_line_fill_buffer_pkg;

  // Fill sequencing states
  typedef enum logic [1:0] {
    FILL_IDLE   = 2'd0,
    FILL_ARMED  = 2'd1,
    FILL_FILL   = 2'd2,
    FILL_COMMIT = 2'd3
  } fill_state_t;

  // Number of backend beats in one line
  function automatic int calc_nb(input int l2m);
    return 1 << l2m;
  endfunction

  // Width of a whole line in bits
  function automatic int calc_line_w(input int l2m, input int bd);
    return calc_nb(l2m) * bd;
  endfunction

  // Byte-offset bits covered by one backend beat
  function automatic int calc_bb(input int bd);
    return $clog2(bd / 8);
  endfunction

endpackage

// File: rtl/cache_line_fill_buffer_fill_word_select.sv
// Picks the requested frontend word out of an assembled line: the upper
// offset bits choose the beat, the lower offset bits choose the word inside it.
module fill_word_select #(
  parameter int BD    = 32,
  parameter int FD    = 32,
  parameter int L2M   = 3,
  parameter int OFF_W = 3
) (
  input  logic [(BD << L2M)-1:0] line,
  input  logic [OFF_W-1:0]       word_off,
  output logic [FD-1:0]          word
);

  localparam int SLICE_W = OFF_W - L2M;

  logic [BD-1:0] beat;

  generate
    if (L2M > 0) begin : g_beat_mux
      logic [L2M-1:0] beat_idx;
      assign beat_idx = word_off[OFF_W-1 -: L2M];
      assign beat     = line[beat_idx*BD +: BD];
    end else begin : g_one_beat
      assign beat = line[BD-1:0];
    end

    if (SLICE_W > 0) begin : g_slice_mux
      logic [SLICE_W-1:0] slice_idx;
      assign slice_idx = word_off[SLICE_W-1:0];
      assign word      = beat[slice_idx*FD +: FD];
    end else begin : g_whole_beat
      assign word = beat[FD-1:0];
    end
  endgenerate

endmodule

// File: rtl/cache_line_fill_buffer.sv
// Line fill buffer: collects backend beats for a missed line, then writes the
// full line to data memory and forwards the critical word in one commit cycle.
// An incomplete burst is reported with a one-cycle fill_error instead.
module cache_line_fill_buffer
  import cache_line_fill_buffer_pkg::*;
#(
  parameter int CACHE_FRONTEND_ADDR_W = 32,
  parameter int CACHE_FRONTEND_DATA_W = 32,
  parameter int CACHE_BACKEND_DATA_W  = CACHE_FRONTEND_DATA_W,
  parameter int CACHE_WORD_OFF_W      = 3,
  parameter int CACHE_LINE2MEM_W      = CACHE_WORD_OFF_W
                                        - $clog2(CACHE_BACKEND_DATA_W / CACHE_FRONTEND_DATA_W),
  localparam int NB     = calc_nb(CACHE_LINE2MEM_W),
  localparam int LINE_W = calc_line_w(CACHE_LINE2MEM_W, CACHE_BACKEND_DATA_W),
  localparam int BB     = calc_bb(CACHE_BACKEND_DATA_W),
  localparam int IDX_W  = CACHE_FRONTEND_ADDR_W - BB - CACHE_LINE2MEM_W,
  localparam int RA_W   = (CACHE_LINE2MEM_W > 0) ? CACHE_LINE2MEM_W : 1
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst_n,
  input  logic                             replace_valid,
  input  logic [IDX_W-1:0]                 replace_addr,
  input  logic [CACHE_WORD_OFF_W-1:0]      req_word_off,
  input  logic                             replace,
  input  logic                             read_valid,
  input  logic [RA_W-1:0]                  read_addr,
  input  logic [CACHE_BACKEND_DATA_W-1:0]  read_rdata,
  output logic                             fill_busy,
  output logic [IDX_W-1:0]                 fill_index,
  output logic                             line_we,
  output logic [LINE_W-1:0]                line_wdata,
  output logic                             fwd_valid,
  output logic [CACHE_FRONTEND_DATA_W-1:0] fwd_rdata,
  output logic                             fill_done,
  output logic                             fill_error
);

  localparam int BD = CACHE_BACKEND_DATA_W;

  fill_state_t                 state;
  logic [CACHE_WORD_OFF_W-1:0] word_off;
  logic [NB-1:0]               mask;
  logic [LINE_W-1:0]           line;
  logic [RA_W-1:0]             beat_sel;
  logic [NB-1:0]               beat_bit;
  logic [NB-1:0]               mask_upd;
  logic                        accept;
  logic                        mask_full;

  // With a single-beat line every beat lands in slot 0 and read_addr is moot
  generate
    if (CACHE_LINE2MEM_W > 0) begin : g_multi_beat
      assign beat_sel = read_addr;
    end else begin : g_single_beat
      logic unused_read_addr;
      assign unused_read_addr = ^read_addr;
      assign beat_sel         = '0;
    end
  endgenerate

  // A new miss starts from an empty mask; a beat arriving on the same edge
  // still counts so the mask always reflects what the line register holds.
  assign accept    = (state == FILL_IDLE) && replace_valid;
  assign beat_bit  = read_valid ? (NB'(1) << beat_sel) : '0;
  assign mask_upd  = (accept ? '0 : mask) | beat_bit;
  assign mask_full = &mask_upd;

  // Beat capture: any state, repeated indices simply overwrite
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      mask <= '0;
      line <= '0;
    end else begin
      mask <= mask_upd;
      if (read_valid) begin
        line[beat_sel*BD +: BD] <= read_rdata;
      end
    end
  end

  // Fill sequencing with registered one-cycle strobes
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state      <= FILL_IDLE;
      fill_index <= '0;
      word_off   <= '0;
      line_we    <= 1'b0;
      fill_done  <= 1'b0;
      fwd_valid  <= 1'b0;
      fill_error <= 1'b0;
    end else begin
      line_we    <= 1'b0;
      fill_done  <= 1'b0;
      fwd_valid  <= 1'b0;
      fill_error <= 1'b0;
      case (state)
        FILL_IDLE: begin
          if (replace_valid) begin
            state      <= FILL_ARMED;
            fill_index <= replace_addr;
            word_off   <= req_word_off;
          end
        end
        FILL_ARMED: begin
          if (replace) begin
            state <= FILL_FILL;
          end
        end
        FILL_FILL: begin
          if (!replace) begin
            if (mask_full) begin
              state     <= FILL_COMMIT;
              line_we   <= 1'b1;
              fill_done <= 1'b1;
              fwd_valid <= 1'b1;
            end else begin
              state      <= FILL_IDLE;
              fill_error <= 1'b1;
            end
          end
        end
        FILL_COMMIT: begin
          state <= FILL_IDLE;
        end
        default: begin
          state <= FILL_IDLE;
        end
      endcase
    end
  end

  assign fill_busy  = (state != FILL_IDLE);
  assign line_wdata = line;

  fill_word_select #(
    .BD    (BD),
    .FD    (CACHE_FRONTEND_DATA_W),
    .L2M   (CACHE_LINE2MEM_W),
    .OFF_W (CACHE_WORD_OFF_W)
  ) u_fill_word_select (
    .line     (line),
    .word_off (word_off),
    .word     (fwd_rdata)
  );

endmodule

// File: tb/tb_cache_line_fill_buffer.sv
// Bench for the line fill buffer: directed scenarios plus randomized fills on
// the nominal 32/32 configuration, and a directed check of a 64-bit backend.
module tb_cache_line_fill_buffer;

  logic         ap_clk;
  logic         ap_rst_n;

  // nominal instance: FD=BD=32, L2M=3
  logic         replace_valid;
  logic [26:0]  replace_addr;
  logic [2:0]   req_word_off;
  logic         replace;
  logic         read_valid;
  logic [2:0]   read_addr;
  logic [31:0]  read_rdata;
  logic         fill_busy;
  logic [26:0]  fill_index;
  logic         line_we;
  logic [255:0] line_wdata;
  logic         fwd_valid;
  logic [31:0]  fwd_rdata;
  logic         fill_done;
  logic         fill_error;

  // wide-beat instance: FD=32, BD=64, L2M=2
  logic         b_replace_valid;
  logic [26:0]  b_replace_addr;
  logic [2:0]   b_req_word_off;
  logic         b_replace;
  logic         b_read_valid;
  logic [1:0]   b_read_addr;
  logic [63:0]  b_read_rdata;
  logic         b_fill_busy;
  logic [26:0]  b_fill_index;
  logic         b_line_we;
  logic [255:0] b_line_wdata;
  logic         b_fwd_valid;
  logic [31:0]  b_fwd_rdata;
  logic         b_fill_done;
  logic         b_fill_error;

  cache_line_fill_buffer dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .replace_valid (replace_valid),
    .replace_addr  (replace_addr),
    .req_word_off  (req_word_off),
    .replace       (replace),
    .read_valid    (read_valid),
    .read_addr     (read_addr),
    .read_rdata    (read_rdata),
    .fill_busy     (fill_busy),
    .fill_index    (fill_index),
    .line_we       (line_we),
    .line_wdata    (line_wdata),
    .fwd_valid     (fwd_valid),
    .fwd_rdata     (fwd_rdata),
    .fill_done     (fill_done),
    .fill_error    (fill_error)
  );

  cache_line_fill_buffer #(
    .CACHE_BACKEND_DATA_W (64)
  ) dut_b (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .replace_valid (b_replace_valid),
    .replace_addr  (b_replace_addr),
    .req_word_off  (b_req_word_off),
    .replace       (b_replace),
    .read_valid    (b_read_valid),
    .read_addr     (b_read_addr),
    .read_rdata    (b_read_rdata),
    .fill_busy     (b_fill_busy),
    .fill_index    (b_fill_index),
    .line_we       (b_line_we),
    .line_wdata    (b_line_wdata),
    .fwd_valid     (b_fwd_valid),
    .fwd_rdata     (b_fwd_rdata),
    .fill_done     (b_fill_done),
    .fill_error    (b_fill_error)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge ap_clk);
    cyc++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model (transaction level) ----------------
  // The model remembers which beats of the current miss were delivered and
  // the cycle windows in which busy / commit / error must be observed.
  logic [31:0]  m_beat [8];
  bit           m_have [8];
  logic [26:0]  m_index;
  int           m_off;
  int           busy_lo    = -1;
  int           busy_hi    = -2;
  int           commit_cyc = -1;
  int           err_cyc    = -1;
  logic [255:0] exp_line;
  logic [31:0]  exp_fwd;
  bit           in_reset   = 1'b0;
  bit           run_checks = 1'b0;
  bit           hold_valid = 1'b0;
  logic [255:0] hold_line;
  logic [26:0]  hold_index;
  logic [255:0] cap_line;
  logic [31:0]  cap_fwd;
  logic [26:0]  cap_index;
  int           n_we  = 0;
  int           n_err = 0;

  // Compare process: every cycle, on the falling edge
  initial forever begin
    @(negedge ap_clk);
    if (in_reset) begin
      check("rst_busy",  fill_busy,  1'b0);
      check("rst_we",    line_we,    1'b0);
      check("rst_done",  fill_done,  1'b0);
      check("rst_fwdv",  fwd_valid,  1'b0);
      check("rst_err",   fill_error, 1'b0);
      check("rst_index", fill_index, 27'h0);
      check("rst_line",  line_wdata, 256'h0);
      check("rst_fwd",   fwd_rdata,  32'h0);
    end else if (run_checks) begin
      if (line_we) begin
        n_we++;
        cap_line  = line_wdata;
        cap_fwd   = fwd_rdata;
        cap_index = fill_index;
      end
      if (fill_error) n_err++;
      check("fill_busy",  fill_busy,  (cyc >= busy_lo) && (cyc <= busy_hi));
      check("line_we",    line_we,    cyc == commit_cyc);
      check("fill_done",  fill_done,  cyc == commit_cyc);
      check("fwd_valid",  fwd_valid,  cyc == commit_cyc);
      check("fill_error", fill_error, cyc == err_cyc);
      if (cyc == commit_cyc) begin
        check("commit_line",  line_wdata, exp_line);
        check("commit_fwd",   fwd_rdata,  exp_fwd);
        check("commit_index", fill_index, m_index);
        hold_valid = 1'b1;
        hold_line  = exp_line;
        hold_index = m_index;
      end else if (hold_valid) begin
        check("hold_line",  line_wdata, hold_line);
        check("hold_index", fill_index, hold_index);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset(input int n);
    in_reset   = 1'b1;
    ap_rst_n   = 1'b0;
    hold_valid = 1'b0;
    busy_lo    = -1;
    busy_hi    = -2;
    commit_cyc = -1;
    err_cyc    = -1;
    replace    = 1'b0;
    read_valid = 1'b0;
    idle(n);
    ap_rst_n = 1'b1;
    in_reset = 1'b0;
  endtask

  task automatic start_fill(input logic [26:0] addr, input int off);
    hold_valid    = 1'b0;
    replace_valid = 1'b1;
    replace_addr  = addr;
    req_word_off  = 3'(off);
    m_index       = addr;
    m_off         = off;
    for (int i = 0; i < 8; i++) m_have[i] = 1'b0;
    busy_lo = cyc + 1;
    busy_hi = 1 << 30;
    tick();
    replace_valid = 1'b0;
    replace_addr  = 27'($urandom);
    req_word_off  = 3'($urandom);
  endtask

  task automatic raise_replace();
    replace = 1'b1;
    tick();
  endtask

  task automatic send_beat(input int idx, input logic [31:0] data, input bit rv_pulse);
    read_valid    = 1'b1;
    read_addr     = 3'(idx);
    read_rdata    = data;
    replace_valid = rv_pulse;
    replace_addr  = 27'($urandom);
    m_beat[idx]   = data;
    m_have[idx]   = 1'b1;
    tick();
    read_valid    = 1'b0;
    replace_valid = 1'b0;
    read_rdata    = 32'($urandom);
  endtask

  // Drop replace; the sampling edge decides commit versus error
  task automatic finish_fill();
    bit full;
    replace = 1'b0;
    tick();
    full = 1'b1;
    for (int i = 0; i < 8; i++) if (!m_have[i]) full = 1'b0;
    if (full) begin
      for (int i = 0; i < 8; i++) exp_line[i*32 +: 32] = m_beat[i];
      exp_fwd    = m_beat[m_off];
      commit_cyc = cyc;
      busy_hi    = cyc;
    end else begin
      err_cyc = cyc;
      busy_hi = cyc - 1;
    end
    tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int we0;
    int err0;
    ap_rst_n        = 1'b1;
    replace_valid   = 1'b0;
    replace_addr    = '0;
    req_word_off    = '0;
    replace         = 1'b0;
    read_valid      = 1'b0;
    read_addr       = '0;
    read_rdata      = '0;
    b_replace_valid = 1'b0;
    b_replace_addr  = '0;
    b_req_word_off  = '0;
    b_replace       = 1'b0;
    b_read_valid    = 1'b0;
    b_read_addr     = '0;
    b_read_rdata    = '0;
    #1;
    do_reset(3);
    run_checks = 1'b1;
    idle(2);

    // nominal back-to-back burst
    we0 = n_we;
    start_fill(27'h1234, 5);
    raise_replace();
    for (int i = 0; i < 8; i++) send_beat(i, 32'hA0 + 32'(i), 1'b0);
    finish_fill();
    idle(2);
    check("nom_line", cap_line,
          256'h000000A7_000000A6_000000A5_000000A4_000000A3_000000A2_000000A1_000000A0);
    check("nom_fwd",   cap_fwd,   32'hA5);
    check("nom_index", cap_index, 27'h1234);
    check("nom_we_count", n_we - we0, 1);

    // gapped burst gives the same line
    we0 = n_we;
    cap_line = '0;
    start_fill(27'h1234, 5);
    raise_replace();
    for (int i = 0; i < 8; i++) begin
      send_beat(i, 32'hA0 + 32'(i), 1'b0);
      idle(2);
    end
    finish_fill();
    idle(2);
    check("gap_line", cap_line,
          256'h000000A7_000000A6_000000A5_000000A4_000000A3_000000A2_000000A1_000000A0);
    check("gap_fwd", cap_fwd, 32'hA5);
    check("gap_we_count", n_we - we0, 1);

    // retried burst overwrites, single commit
    we0 = n_we;
    start_fill(27'h0BEEF, 2);
    raise_replace();
    for (int i = 0; i < 8; i++) send_beat(i, 32'hEE, 1'b0);
    for (int i = 0; i < 8; i++) send_beat(i, 32'hB0 + 32'(i), 1'b0);
    finish_fill();
    idle(2);
    check("retry_line", cap_line,
          256'h000000B7_000000B6_000000B5_000000B4_000000B3_000000B2_000000B1_000000B0);
    check("retry_fwd", cap_fwd, 32'hB2);
    check("retry_we_count", n_we - we0, 1);

    // incomplete burst reports an error
    we0  = n_we;
    err0 = n_err;
    start_fill(27'h00777, 1);
    raise_replace();
    for (int i = 0; i < 5; i++) send_beat(i, 32'hC0 + 32'(i), 1'b0);
    finish_fill();
    idle(2);
    check("inc_err_count", n_err - err0, 1);
    check("inc_we_count",  n_we - we0,  0);

    // reset mid-fill, then a fill missing beat 2
    we0  = n_we;
    err0 = n_err;
    start_fill(27'h00321, 0);
    raise_replace();
    for (int i = 0; i < 3; i++) send_beat(i, 32'hD0 + 32'(i), 1'b0);
    do_reset(2);
    idle(1);
    start_fill(27'h00654, 3);
    raise_replace();
    for (int i = 0; i < 8; i++) if (i != 2) send_beat(i, 32'hE0 + 32'(i), 1'b0);
    finish_fill();
    idle(2);
    check("rst_fill_err_count", n_err - err0, 1);
    check("rst_fill_we_count",  n_we - we0,  0);

    // randomized fills
    for (int t = 0; t < 40; t++) begin
      bit lossy;
      int order [8];
      lossy = ($urandom_range(0, 3) == 0);
      start_fill(27'($urandom), int'($urandom_range(0, 7)));
      for (int k = $urandom_range(0, 2); k > 0; k--)
        send_beat(int'($urandom_range(0, 7)), $urandom, 1'b0);
      idle(int'($urandom_range(0, 2)));
      raise_replace();
      for (int i = 0; i < 8; i++) order[i] = i;
      for (int i = 7; i > 0; i--) begin
        int j;
        int tmp;
        j = int'($urandom_range(0, i));
        tmp = order[i];
        order[i] = order[j];
        order[j] = tmp;
      end
      for (int i = 0; i < 8; i++) begin
        if (!(lossy && $urandom_range(0, 3) == 0))
          send_beat(order[i], $urandom, $urandom_range(0, 7) == 0);
        if ($urandom_range(0, 4) == 0)
          send_beat(int'($urandom_range(0, 7)), $urandom, 1'b0);
        idle(int'($urandom_range(0, 2)));
      end
      finish_fill();
      idle(int'($urandom_range(0, 2)));
    end

    // wide-beat instance: off=5 picks beat 2 upper half; stray request ignored
    b_replace_valid = 1'b1;
    b_replace_addr  = 27'h0ABCDE;
    b_req_word_off  = 3'd5;
    tick();
    b_replace_valid = 1'b0;
    b_replace       = 1'b1;
    tick();
    check("b_busy_fill", b_fill_busy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      b_read_valid    = 1'b1;
      b_read_addr     = 2'(i);
      b_read_rdata    = {32'h1111_0000 + 32'(2*i+1), 32'h1111_0000 + 32'(2*i)};
      b_replace_valid = (i == 1);
      b_replace_addr  = 27'h7FFFFFF;
      b_req_word_off  = 3'd0;
      tick();
    end
    b_read_valid    = 1'b0;
    b_replace_valid = 1'b0;
    b_replace       = 1'b0;
    tick();
    check("b_line_we",   b_line_we,   1'b1);
    check("b_fwd_valid", b_fwd_valid, 1'b1);
    check("b_fwd_rdata", b_fwd_rdata, 32'h1111_0005);
    check("b_index",     b_fill_index, 27'h0ABCDE);
    check("b_line_beat2", b_line_wdata[191:128], 64'h1111_0005_1111_0004);
    tick();
    check("b_we_pulse", b_line_we,   1'b0);
    check("b_busy_end", b_fill_busy, 1'b0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
